// File: rtl/fft_pkg.sv
// Shared FFT datapath types: 16-bit signed complex samples and Q1.15 twiddles.
// Also holds the saturating narrowing used on butterfly outputs.
package fft_pkg;

  localparam int DATA_W  = 16;
  localparam int TW_FRAC = 15;

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } cplx_t;

  function automatic logic signed [DATA_W-1:0] sat16(input logic signed [17:0] x);
    if (x > 18'sd32767)
      return 16'sh7FFF;
    else if (x < -18'sd32768)
      return 16'sh8000;
    else
      return x[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/butterfly_unit_if.sv
// Operand/result bundle between the FFT stage controller and the butterfly.
// Producer-driven valid only; the consumer takes every result, no ready path.
interface butterfly_unit_if;

  logic            in_valid;
  fft_pkg::cplx_t  a_in;
  fft_pkg::cplx_t  b_in;
  fft_pkg::cplx_t  w_in;
  fft_pkg::cplx_t  a_out;
  fft_pkg::cplx_t  b_out;
  logic            out_valid;

  modport master (
    output in_valid, a_in, b_in, w_in,
    input  a_out, b_out, out_valid
  );

  modport slave (
    input  in_valid, a_in, b_in, w_in,
    output a_out, b_out, out_valid
  );

endinterface

// File: rtl/cmul_q15.sv
// Complex B*W with Q1.15 twiddle, rounded half-up to 18 bits; 1-cycle latency.
// Free-running pipeline stage, no backpressure.
module cmul_q15
  import fft_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  cplx_t              b,
  input  cplx_t              w,
  output logic signed [17:0] t_re,
  output logic signed [17:0] t_im
);

  logic signed [31:0] m_rr, m_ii, m_ri, m_ir;
  logic signed [32:0] p_re_d, p_im_d;
  logic signed [32:0] p_re, p_im;

  always_comb begin
    m_rr   = 32'(b.re) * 32'(w.re);
    m_ii   = 32'(b.im) * 32'(w.im);
    m_ri   = 32'(b.re) * 32'(w.im);
    m_ir   = 32'(b.im) * 32'(w.re);
    p_re_d = 33'(m_rr) - 33'(m_ii);
    p_im_d = 33'(m_ri) + 33'(m_ir);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_re <= '0;
      p_im <= '0;
    end else begin
      p_re <= p_re_d;
      p_im <= p_im_d;
    end
  end

  // Bias then arithmetic shift: ties round toward +inf, negatives floor.
  assign t_re = 18'((p_re + 33'sd16384) >>> TW_FRAC);
  assign t_im = 18'((p_im + 33'sd16384) >>> TW_FRAC);

endmodule

// File: rtl/butterfly_unit.sv
// Radix-2 DIT butterfly A+W*B / A-W*B with saturation; 2-cycle latency, 1/cycle.
// No backpressure: every out_valid cycle must be consumed.
module butterfly_unit
  import fft_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  butterfly_unit_if.slave  bus
);

  logic signed [17:0] t_re, t_im;
  cplx_t              a_d;
  logic               vld_d;
  logic signed [17:0] sum_re, sum_im, dif_re, dif_im;

  cmul_q15 u_cmul (
    .clk   (clk),
    .rst_n (rst_n),
    .b     (bus.b_in),
    .w     (bus.w_in),
    .t_re  (t_re),
    .t_im  (t_im)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_d   <= '0;
      vld_d <= 1'b0;
    end else begin
      a_d   <= bus.a_in;
      vld_d <= bus.in_valid;
    end
  end

  always_comb begin
    sum_re = 18'(a_d.re) + t_re;
    sum_im = 18'(a_d.im) + t_im;
    dif_re = 18'(a_d.re) - t_re;
    dif_im = 18'(a_d.im) - t_im;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.a_out     <= '0;
      bus.b_out     <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.a_out     <= '{re: sat16(sum_re), im: sat16(sum_im)};
      bus.b_out     <= '{re: sat16(dif_re), im: sat16(dif_im)};
      bus.out_valid <= vld_d;
    end
  end

endmodule

// File: tb/tb_butterfly_unit.sv
// Directed-vector bench for butterfly_unit with hand-computed expected results.
module tb_butterfly_unit;
  import fft_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  butterfly_unit_if bus ();

  butterfly_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam int NV = 5;
  // Inputs: A, B, W (W as signed Q1.15 integers).
  int a_re [NV] = '{100, 1023, 1023, 0, 32767};
  int a_im [NV] = '{0, 0, 0, 0, 0};
  int b_re [NV] = '{100, 1023, -1024, 100, 32767};
  int b_im [NV] = '{0, 0, 0, 0, 0};
  int w_re [NV] = '{23170, 32767, 32767, 0, 32767};
  int w_im [NV] = '{-23170, 0, 0, -32768, 0};
  // Expected outputs.
  int xa_re [NV] = '{171, 2046, -1, 0, 32767};
  int xa_im [NV] = '{-71, 0, 0, -100, 0};
  int xb_re [NV] = '{29, 0, 2047, 0, 1};
  int xb_im [NV] = '{71, 0, 0, 100, 0};

  task automatic check(input string tag, input int obs, input int exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input int i, input logic vld);
    bus.in_valid = vld;
    bus.a_in = '{re: 16'(a_re[i]), im: 16'(a_im[i])};
    bus.b_in = '{re: 16'(b_re[i]), im: 16'(b_im[i])};
    bus.w_in = '{re: 16'(w_re[i]), im: 16'(w_im[i])};
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.a_in = '0;
    bus.b_in = '0;
    bus.w_in = '0;
  endtask

  task automatic check_out(input string tag, input int i);
    check({tag, ".vld"},  int'(bus.out_valid), 1);
    check({tag, ".a_re"}, int'(bus.a_out.re), xa_re[i]);
    check({tag, ".a_im"}, int'(bus.a_out.im), xa_im[i]);
    check({tag, ".b_re"}, int'(bus.b_out.re), xb_re[i]);
    check({tag, ".b_im"}, int'(bus.b_out.im), xb_im[i]);
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.vld",  int'(bus.out_valid), 0);
    check("rst.a",    int'(bus.a_out), 0);
    check("rst.b",    int'(bus.b_out), 0);
    rst_n = 1'b1;

    // Isolated butterflies: valid only two edges after capture.
    for (int i = 0; i < NV; i++) begin
      drive(i, 1'b1);
      @(posedge clk); #1;
      idle();
      check($sformatf("single%0d.mid_vld", i), int'(bus.out_valid), 0);
      @(posedge clk); #1;
      check_out($sformatf("single%0d", i), i);
      @(posedge clk); #1;
      check($sformatf("single%0d.post_vld", i), int'(bus.out_valid), 0);
    end

    // Back-to-back stream: results emerge in order, one per cycle.
    for (int i = 0; i <= NV; i++) begin
      if (i < NV) drive(i, 1'b1);
      else        idle();
      @(posedge clk); #1;
      if (i >= 1) check_out($sformatf("stream%0d", i - 1), i - 1);
    end
    @(posedge clk); #1;
    check("stream.tail_vld", int'(bus.out_valid), 0);

    // Reset mid-stream flushes in-flight work.
    drive(0, 1'b1);
    @(posedge clk); #1;
    drive(1, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive(2, 1'b1);
    #1;
    check("flush.vld", int'(bus.out_valid), 0);
    check("flush.a",   int'(bus.a_out), 0);
    check("flush.b",   int'(bus.b_out), 0);
    @(posedge clk); #1;
    check("flush.hold_vld", int'(bus.out_valid), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    idle();
    check("flush.no_spurious", int'(bus.out_valid), 0);
    @(posedge clk); #1;
    check_out("flush.next", 2);
    @(posedge clk); #1;
    check("flush.end_vld", int'(bus.out_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
